// File: rtl/pixel_arb_pkg.sv
// pixel_arb_pkg: shared state encoding and pointer sizing for the pixel port arbiter
package pixel_arb_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} pixel_arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int PTR_WIDTH = ptr_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker, first set request at or above ptr with wrap
module rr_select
    import pixel_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any_valid
);

    logic [PW-1:0] idx;

    // scan from the farthest offset down so the closest request to ptr wins
    always_comb begin
        grant = '0;
        idx = '0;
        any_valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) grant = idx;
        end
    end

endmodule

// File: rtl/pixel_port_arbiter.sv
// pixel_port_arbiter: round-robin sharing of the external pixel fetch port; optional WAIT timeout via PIXEL_ARB_TIMEOUT_EN
module pixel_port_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         addr_pixel,
    output logic                          request_pixel,
    input  logic [DATA_WIDTH-1:0]         pixel,
    input  logic                          pixel_avail,
    output logic                          busy
);

    localparam int PW = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pixel_port_arbiter: parameter out of range");
    end

    pixel_arb_state_t      state, state_d;
    logic [PW-1:0]         ptr, ptr_d, g, g_d, sel;
    logic                  any;
    logic [NUM_REQ-1:0]    req_ready_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  request_d, rsp_err_d, timeout;

`ifdef PIXEL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // count cycles spent in WAIT; clears whenever WAIT is left
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) cnt <= '0;
        else cnt <= (state == WAIT && state_d == WAIT) ? cnt + 1'b1 : '0;
    end
    assign timeout = (state == WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    rr_select #(.N(NUM_REQ), .PW(PW)) u_sel (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (sel),
        .any_valid(any)
    );

    // next-state and next-output logic; every output is the registered copy of a *_d value
    always_comb begin
        state_d = state;
        ptr_d = ptr;
        g_d = g;
        addr_d = addr_pixel;
        request_d = request_pixel;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d = '0;
        rsp_err_d = 1'b0;
        case (state)
            IDLE: if (any) begin
                state_d = WAIT;
                g_d = sel;
                ptr_d = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                addr_d = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
                request_d = 1'b1;
                req_ready_d[sel] = 1'b1;
            end
            WAIT: if (pixel_avail || timeout) begin
                state_d = RESP;
                request_d = 1'b0;
                rsp_valid_d[g] = 1'b1;
                rsp_data_d = pixel_avail ? pixel : '0;
                rsp_err_d = !pixel_avail;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            ptr <= '0;
            g <= '0;
            addr_pixel <= '0;
            request_pixel <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            g <= g_d;
            addr_pixel <= addr_d;
            request_pixel <= request_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data <= rsp_data_d;
            rsp_err <= rsp_err_d;
            busy <= state_d != IDLE;
        end
    end

endmodule

// File: doc/pixel_port_arbiter.md
Name: pixel_port_arbiter

Overview:
- Shares the single external pixel fetch port (addr_pixel / request_pixel / pixel / pixel_avail) of the memory controller between NUM_REQ internal requesters (e.g. memory-controller NoC request path, AXI-light priority path, spoon-feed prefetcher).
- Round-robin grant, one outstanding transaction at a time.
- Registers the external handshake and routes the returned pixel to the granted requester only.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 32: pixel address width.
- DATA_WIDTH, 32: pixel data width.
- TIMEOUT_CYCLES, 1023: WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- res_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready pulse.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response pulse.
- rsp_data  out  DATA_WIDTH  response pixel; valid only while rsp_valid is non-zero.
- rsp_err  out  1  response is a timeout (optional feature); 0 otherwise.
- addr_pixel  out  ADDR_WIDTH  external pixel address.
- request_pixel  out  1  external request level.
- pixel  in  DATA_WIDTH  external pixel data.
- pixel_avail  in  1  external data-valid strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, WAIT, RESP.
- IDLE, any req_valid high:
  - Pick the first set bit searching from the pointer upward with wrap-around.
  - Next edge: latch its address into addr_pixel, set request_pixel=1, pulse req_ready[g] for one cycle, set pointer=(g+1) mod NUM_REQ, go to WAIT.
- WAIT:
  - request_pixel and addr_pixel stay stable.
  - On an edge where pixel_avail=1: rsp_data<=pixel, rsp_valid[g]<=1, request_pixel<=0, go to RESP.
- RESP: rsp_valid clears. Next edge goes to IDLE.
- Re-arbitration starts in IDLE only. Minimum spacing between grants is 3 cycles.
- Latency: req_valid sampled at edge N gives req_ready and request_pixel high in cycle N+1. pixel_avail sampled at edge M gives rsp_valid high in cycle M+1.
- Handling of unusual input conditions:
  - pixel_avail high in IDLE or RESP: ignored.
  - pixel_avail high on the same edge WAIT is entered: not possible, because WAIT is entered by that edge.
  - A requester dropping req_valid before its grant: allowed; it is not served.
  - Requests from other requesters while WAIT is active: they stay pending.
  - All NUM_REQ requesting continuously: each is served exactly once per NUM_REQ grants.
- Pointer wrap: after granting NUM_REQ-1, the pointer becomes 0.
- Reset asserted mid-transaction: immediately return to IDLE with outputs 0. A pixel_avail arriving later is discarded.

Optional Feature:
- Macro: PIXEL_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - When the count reaches TIMEOUT_CYCLES with no pixel_avail: rsp_valid[g]=1, rsp_err=1, rsp_data=0, request_pixel=0, go to RESP.
  - The counter clears on leaving WAIT.
- Undefined: no counter; WAIT lasts indefinitely; rsp_err is tied to 0.

Decomposition:
- Package pixel_arb_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} pixel_arb_state_t.
  - Localparam for the pointer width, $clog2(NUM_REQ).
- Sub-module rr_select: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any_valid.
  - Reusable by other arbiters in the codebase.

Test Plan:
1. Single request: req_valid=4'b0001, addr 0x100; pixel_avail with 0xDEADBEEF 5 cycles after request_pixel rises -> addr_pixel=0x100, req_ready=0001 one cycle later, rsp_valid=0001 with rsp_data=0xDEADBEEF one cycle after pixel_avail, busy back to 0 after RESP.
2. Round-robin fairness: req_valid=4'b1111 held, pixel_avail returned 2 cycles after each request -> grant order 0,1,2,3,0; no requester granted twice within 4 grants.
3. Pointer wrap: pointer=3 (after granting 2), req_valid=4'b1001 -> grant 3, then 0.
4. Spurious strobe: pixel_avail pulsed in IDLE with no request -> no rsp_valid, state stays IDLE.
5. Reset mid-WAIT: res_n low during WAIT -> request_pixel=0 and busy=0 asynchronously; a pixel_avail after reset release produces no response.
6. With PIXEL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: never assert pixel_avail -> after 8 WAIT cycles rsp_valid[g]=1, rsp_err=1, rsp_data=0, request_pixel=0.
